id_ex_pipeline_reg: RTL

- Decode→execute pipeline register; sits directly downstream of the register file.
- Captures the register file read data (rdat1/rdat2) plus decode control and immediate fields, and presents them registered to the execute stage.
- Applies write-through bypass from the writeback port, because the register file updates on the same edge the decode stage samples.
- Supports stall (hold), flush (bubble) and a global advance enable tied to the cache hit.

---
 rtl/id_ex_pipeline_reg.sv | 87 ++++++++
 1 files changed

// File: rtl/id_ex_pipeline_reg.sv
// id_ex_pipeline_reg: decode->execute pipeline register with writeback bypass,
// stall/enable hold, flush bubble and sticky halt.
module id_ex_pipeline_reg #(
  parameter int WORD_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               en,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [WORD_W-1:0]  id_pc,
  input  logic [REG_AW-1:0]  id_rsel1,
  input  logic [REG_AW-1:0]  id_rsel2,
  input  logic [WORD_W-1:0]  id_rdat1,
  input  logic [WORD_W-1:0]  id_rdat2,
  input  logic [WORD_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  id_wsel,
  input  logic               id_wen,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_alusrc,
  input  logic               id_halt,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               wb_wen,
  input  logic [REG_AW-1:0]  wb_wsel,
  input  logic [WORD_W-1:0]  wb_wdat,
  output logic               ex_valid,
  output logic [WORD_W-1:0]  ex_pc,
  output logic [WORD_W-1:0]  ex_rdat1,
  output logic [WORD_W-1:0]  ex_rdat2,
  output logic [WORD_W-1:0]  ex_imm,
  output logic [REG_AW-1:0]  ex_rsel1,
  output logic [REG_AW-1:0]  ex_rsel2,
  output logic [REG_AW-1:0]  ex_wsel,
  output logic               ex_wen,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_alusrc,
  output logic               ex_halt,
  output logic [ALUOP_W-1:0] ex_aluop
);
  logic              load;
  logic [WORD_W-1:0] byp1, byp2;
  // The register file writes on the same edge decode samples, so forward the
  // writeback value; $zero is hardwired and never forwarded.
  always_comb begin
    load = en && !stall;
    byp1 = (wb_wen && wb_wsel == id_rsel1 && id_rsel1 != '0) ? wb_wdat : id_rdat1;
    byp2 = (wb_wen && wb_wsel == id_rsel2 && id_rsel2 != '0) ? wb_wdat : id_rdat2;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST || flush) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rdat1    <= '0;
      ex_rdat2    <= '0;
      ex_imm      <= '0;
      ex_rsel1    <= '0;
      ex_rsel2    <= '0;
      ex_wsel     <= '0;
      ex_wen      <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_halt     <= 1'b0;
      ex_aluop    <= '0;
    end else if (load) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_valid ? id_pc : '0;
      ex_rdat1    <= id_valid ? byp1 : '0;
      ex_rdat2    <= id_valid ? byp2 : '0;
      ex_imm      <= id_valid ? id_imm : '0;
      ex_rsel1    <= id_valid ? id_rsel1 : '0;
      ex_rsel2    <= id_valid ? id_rsel2 : '0;
      ex_wsel     <= id_valid ? id_wsel : '0;
      ex_wen      <= id_valid && id_wen && id_wsel != '0;
      ex_memread  <= id_valid && id_memread;
      ex_memwrite <= id_valid && id_memwrite;
      ex_alusrc   <= id_valid && id_alusrc;
      ex_halt     <= ex_halt || (id_valid && id_halt);
      ex_aluop    <= id_valid ? id_aluop : '0;
    end
  end
endmodule
